// File: rtl/ram_rd_stream.sv
// Burst read engine for the ram read port: issues a stepped address sequence, absorbs the
// fixed read latency and presents the words as a valid/ready stream with a last flag.
module ram_rd_stream #(
    parameter int RAM_ADDR_WIDTH = 6,
    parameter int RD_WIDTH       = 16,
    parameter int RD_IND         = 2,
    parameter int LEN_WIDTH      = 6,
    parameter int RD_LAT         = 1
) (
    input  logic                      rd_clk,
    input  logic                      rd_rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [RAM_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_len,
    output logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [RD_WIDTH-1:0]       ram_rd_data,
    output logic [RD_WIDTH-1:0]       m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last,
    output logic                      busy
);
    localparam int DEPTH = RD_LAT + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int OW    = CW + 1;
    localparam logic [RAM_ADDR_WIDTH-1:0] ADDR_STEP = RAM_ADDR_WIDTH'(RD_IND);
    localparam logic [PW-1:0]             PTR_MAX   = PW'(DEPTH - 1);
    localparam logic [PW-1:0]             PTR_ONE   = PW'(1);
    localparam logic [LEN_WIDTH:0]        CNT_ONE   = (LEN_WIDTH+1)'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state_reg, state_next;

    logic [RAM_ADDR_WIDTH-1:0] addr_reg;
    logic [LEN_WIDTH:0]        issue_cnt_reg;
    logic                      busy_reg;
    logic [RD_LAT-1:0]         vld_pipe_reg;
    logic [RD_LAT-1:0]         last_pipe_reg;
    logic [RD_WIDTH-1:0]       fifo_data_reg [DEPTH];
    logic [DEPTH-1:0]          fifo_last_reg;
    logic [PW-1:0]             wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]             count_reg;

    logic          accept, issue, issue_last, push, pop, last_pop, credit;
    logic [OW-1:0] occ;

    assign cmd_ready   = (state_reg == IDLE) && !rd_rst;
    assign ram_rd_addr = addr_reg;
    assign busy        = busy_reg;
    assign m_valid     = (count_reg != '0);
    assign m_data      = fifo_data_reg[rd_ptr_reg];
    assign m_last      = m_valid && fifo_last_reg[rd_ptr_reg];

    assign pop        = m_valid && m_ready;
    assign last_pop   = pop && m_last;
    assign push       = vld_pipe_reg[RD_LAT-1];
    assign issue_last = issue && (issue_cnt_reg == CNT_ONE);

    // Reads in flight plus words already buffered must fit the FIFO; a pop this cycle frees a slot.
    always_comb begin
        occ = OW'(count_reg);
        for (int i = 0; i < RD_LAT; i++) begin
            occ = occ + OW'(vld_pipe_reg[i]);
        end
        credit = ((occ - OW'(pop)) < OW'(DEPTH));
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (credit) begin
                    issue = 1'b1;
                    if (issue_cnt_reg == CNT_ONE) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            addr_reg      <= '0;
            issue_cnt_reg <= '0;
            busy_reg      <= 1'b0;
        end else if (accept) begin
            addr_reg      <= cmd_addr;
            issue_cnt_reg <= {1'b0, cmd_len} + CNT_ONE;
            busy_reg      <= 1'b1;
        end else begin
            if (issue) begin
                addr_reg      <= addr_reg + ADDR_STEP;
                issue_cnt_reg <= issue_cnt_reg - CNT_ONE;
            end
            if (last_pop) begin
                busy_reg <= 1'b0;
            end
        end
    end

    // Issue/last flags travel alongside the ram latency so capture lines up with the returning word.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            vld_pipe_reg  <= '0;
            last_pipe_reg <= '0;
        end else begin
            vld_pipe_reg[0]  <= issue;
            last_pipe_reg[0] <= issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_reg[i]  <= vld_pipe_reg[i-1];
                last_pipe_reg[i] <= last_pipe_reg[i-1];
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            fifo_last_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_reg[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_data_reg[wr_ptr_reg] <= ram_rd_data;
                fifo_last_reg[wr_ptr_reg] <= last_pipe_reg[RD_LAT-1];
                wr_ptr_reg <= (wr_ptr_reg == PTR_MAX) ? '0 : wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_MAX) ? '0 : rd_ptr_reg + PTR_ONE;
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_ram_rd_stream.sv
// Scoreboard bench: two engines (read latency 1 and 3) fed by a ram model whose word at address a is a.
module tb_ram_rd_stream;
    localparam int AW = 6;
    localparam int DW = 16;
    localparam int LW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, cmd_valid, m_ready, sel;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;

    logic          cmd_ready_a, m_valid_a, m_last_a, busy_a;
    logic          cmd_ready_b, m_valid_b, m_last_b, busy_b;
    logic [AW-1:0] ram_rd_addr_a, ram_rd_addr_b;
    logic [DW-1:0] ram_rd_data_a, ram_rd_data_b, m_data_a, m_data_b;
    logic [DW-1:0] rd_b1, rd_b2;

    int tests = 0;
    int fails = 0;
    logic [DW:0] exp_q0[$];
    logic [DW:0] exp_q1[$];

    ram_rd_stream #(.RD_LAT(1)) dut_a (
        .rd_clk(clk), .rd_rst(rst), .cmd_valid(cmd_valid && !sel), .cmd_ready(cmd_ready_a),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_rd_addr(ram_rd_addr_a),
        .ram_rd_data(ram_rd_data_a), .m_data(m_data_a), .m_valid(m_valid_a),
        .m_ready(m_ready), .m_last(m_last_a), .busy(busy_a)
    );

    ram_rd_stream #(.RD_LAT(3)) dut_b (
        .rd_clk(clk), .rd_rst(rst), .cmd_valid(cmd_valid && sel), .cmd_ready(cmd_ready_b),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_rd_addr(ram_rd_addr_b),
        .ram_rd_data(ram_rd_data_b), .m_data(m_data_b), .m_valid(m_valid_b),
        .m_ready(m_ready), .m_last(m_last_b), .busy(busy_b)
    );

    // Ram model: registered read, extra output stages for the latency-3 engine.
    always @(posedge clk) begin
        ram_rd_data_a <= DW'(ram_rd_addr_a);
        rd_b1         <= DW'(ram_rd_addr_b);
        rd_b2         <= rd_b1;
        ram_rd_data_b <= rd_b2;
    end

    wire          cur_cmd_ready = sel ? cmd_ready_b : cmd_ready_a;
    wire          cur_m_valid   = sel ? m_valid_b : m_valid_a;
    wire          cur_busy      = sel ? busy_b : busy_a;
    wire [AW-1:0] cur_rd_addr   = sel ? ram_rd_addr_b : ram_rd_addr_a;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor(input bit s);
        logic        hold, v;
        logic [DW:0] held, got, e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                got = s ? {m_last_b, m_data_b} : {m_last_a, m_data_a};
                v   = s ? m_valid_b : m_valid_a;
                if (hold) check(s ? "hold_b" : "hold_a", 32'({v, got}), 32'({1'b1, held}));
                if (v && m_ready) begin
                    if ((s ? exp_q1.size() : exp_q0.size()) == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_beat(dut %0d): got %0h, expected no beat", s, got);
                    end else begin
                        e = s ? exp_q1.pop_front() : exp_q0.pop_front();
                        check(s ? "beat_b" : "beat_a", 32'(got), 32'(e));
                        $display("[TB] dut %0d beat data=%0d last=%0b", s, got[DW-1:0], got[DW]);
                    end
                end
                hold = v && !m_ready;
                held = got;
            end
        end
    endtask

    initial monitor(1'b0);
    initial monitor(1'b1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_burst(input bit s, input logic [AW-1:0] addr, input logic [LW-1:0] len, input bit rnd);
        int            lat, n, cyc, first, fall, bad;
        logic [AW-1:0] a;
        lat = s ? 3 : 1;
        n   = int'(len) + 1;
        for (int i = 0; i < n; i++) begin
            a = addr + AW'(2 * i);
            if (s) exp_q1.push_back({(i == n - 1), DW'(a)});
            else   exp_q0.push_back({(i == n - 1), DW'(a)});
        end
        sel       = s;
        cmd_addr  = addr;
        cmd_len   = len;
        m_ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        cmd_valid = 1'b1;
        #1;
        check("cmd_ready_idle", 32'(cur_cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = ~addr;
        cmd_len   = ~len;
        check("busy_after_cmd", 32'(cur_busy), 32'd1);
        cyc = 1; first = 0; fall = 0; bad = 0;
        while (cyc < 400) begin
            if (!rnd && cyc <= n) check("rd_addr", 32'(cur_rd_addr), 32'(AW'(addr + AW'(2 * (cyc - 1)))));
            if (first == 0 && cur_m_valid) first = cyc;
            if (!cur_busy) begin
                fall = cyc;
                break;
            end
            if (cur_cmd_ready) bad++;
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        check("busy_fall_seen", 32'(fall != 0), 32'd1);
        check("cmd_ready_while_busy", 32'(bad), 32'd0);
        check("cmd_ready_after", 32'(cur_cmd_ready), 32'd1);
        check("scoreboard_empty", 32'(s ? exp_q1.size() : exp_q0.size()), 32'd0);
        if (!rnd) begin
            check("first_valid_cyc", 32'(first), 32'(lat + 2));
            check("busy_fall_cyc", 32'(fall), 32'(lat + 2 + n));
            check("rd_addr_hold", 32'(cur_rd_addr), 32'(AW'(addr + AW'(2 * n))));
        end
        $display("[TB] dut %0d burst addr=%0d len=%0d rnd=%0b first=%0d fall=%0d", s, addr, len, rnd, first, fall);
        m_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0; m_ready = 1'b1; cmd_addr = '0; cmd_len = '0;
        repeat (3) tick();
        check("rst_cmd_ready", 32'(cmd_ready_a), 32'd0);
        check("rst_m_valid", 32'(m_valid_a), 32'd0);
        check("rst_m_last", 32'(m_last_a), 32'd0);
        check("rst_m_data", 32'(m_data_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_rd_addr", 32'(ram_rd_addr_a), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready_a", 32'(cmd_ready_a), 32'd1);
        check("post_rst_ready_b", 32'(cmd_ready_b), 32'd1);
        tick();

        run_burst(1'b0, 6'd0, 6'd3, 1'b0);
        run_burst(1'b0, 6'd60, 6'd3, 1'b0);
        run_burst(1'b0, 6'd10, 6'd7, 1'b1);
        run_burst(1'b0, 6'd20, 6'd0, 1'b0);

        // Reset three cycles into a stalled burst; nothing from it may surface afterwards.
        sel = 1'b0; m_ready = 1'b0; cmd_addr = 6'd0; cmd_len = 6'd15; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        exp_q0.delete();
        tick();
        rst = 1'b0;
        #1;
        check("midrst_m_valid", 32'(m_valid_a), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_rd_addr", 32'(ram_rd_addr_a), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready_a), 32'd1);
        m_ready = 1'b1;
        repeat (6) tick();
        check("midrst_no_stray", 32'(m_valid_a), 32'd0);
        $display("[TB] dut 0 mid-burst reset applied");
        run_burst(1'b0, 6'd8, 6'd1, 1'b0);

        run_burst(1'b0, 6'd4, 6'd63, 1'b0);
        run_burst(1'b1, 6'd0, 6'd15, 1'b0);
        run_burst(1'b1, 6'd50, 6'd5, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
